// File: rtl/bakraid_pcm_fetch_if.sv
// Bus bundle between the YMZ280B ROM read port, the fetch bridge and the three PCM SDRAM slots.
// The slave modport is the bridge; the master modport is the requester/SDRAM side.
interface bakraid_pcm_fetch_if;
   logic        ROM_RD;
   logic [23:0] ROM_ADDR;
   logic [7:0]  ROM_DOUT;
   logic        ROM_VALID;
   logic        PCM_CS;
   logic        PCM1_CS;
   logic        PCM2_CS;
   logic [21:0] PCM_ADDR;
   logic [21:0] PCM1_ADDR;
   logic [21:0] PCM2_ADDR;
   logic        PCM_OK;
   logic        PCM1_OK;
   logic        PCM2_OK;
   logic [7:0]  PCM_DOUT;
   logic [7:0]  PCM1_DOUT;
   logic [7:0]  PCM2_DOUT;
   logic        BUSY;
   logic        TIMEOUT_ERR;

   modport slave (
      input  ROM_RD, ROM_ADDR,
      input  PCM_OK, PCM1_OK, PCM2_OK,
      input  PCM_DOUT, PCM1_DOUT, PCM2_DOUT,
      output ROM_DOUT, ROM_VALID,
      output PCM_CS, PCM1_CS, PCM2_CS,
      output PCM_ADDR, PCM1_ADDR, PCM2_ADDR,
      output BUSY, TIMEOUT_ERR
   );

   modport master (
      output ROM_RD, ROM_ADDR,
      output PCM_OK, PCM1_OK, PCM2_OK,
      output PCM_DOUT, PCM1_DOUT, PCM2_DOUT,
      input  ROM_DOUT, ROM_VALID,
      input  PCM_CS, PCM1_CS, PCM2_CS,
      input  PCM_ADDR, PCM1_ADDR, PCM2_ADDR,
      input  BUSY, TIMEOUT_ERR
   );
endinterface

// File: rtl/bakraid_pcm_fetch.sv
// YMZ280B sample-ROM byte fetch bridge onto three 4 MB PCM SDRAM slots.
// Optional one-entry last-byte cache enabled by defining BAKRAID_PCM_CACHE_EN.
module bakraid_pcm_fetch #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                   CLK,
   input  logic                   RESET,
   bakraid_pcm_fetch_if.slave     bus
);

   localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   logic [1:0]  r_bank;
   logic [21:0] r_addr;
   logic [7:0]  r_cnt;
   logic [2:0]  r_cs;
   logic [7:0]  r_dout;
   logic        r_valid;
   logic        r_busy;
   logic        r_terr;

   logic [1:0]  w_bank;
   logic        w_ok;
   logic [7:0]  w_din;
   logic        w_hit;

   function automatic logic [2:0] bank_cs(input logic [1:0] bank);
      logic [2:0] cs;
      case (bank)
         2'd0:    cs = 3'b001;
         2'd1:    cs = 3'b010;
         2'd2:    cs = 3'b100;
         default: cs = 3'b000;
      endcase
      return cs;
   endfunction

   assign w_bank = bus.ROM_ADDR[23:22];

   // Only the selected slot's handshake is visible to the FSM.
   always_comb begin
      w_ok  = 1'b0;
      w_din = 8'h00;
      case (r_bank)
         2'd0: begin
            w_ok  = bus.PCM_OK;
            w_din = bus.PCM_DOUT;
         end
         2'd1: begin
            w_ok  = bus.PCM1_OK;
            w_din = bus.PCM1_DOUT;
         end
         2'd2: begin
            w_ok  = bus.PCM2_OK;
            w_din = bus.PCM2_DOUT;
         end
         default: begin
            w_ok  = 1'b0;
            w_din = 8'h00;
         end
      endcase
   end

`ifdef BAKRAID_PCM_CACHE_EN
   logic [23:0] r_tag;
   logic [7:0]  r_cdata;
   logic        r_cvld;

   assign w_hit = r_cvld && (r_tag == bus.ROM_ADDR);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cvld  <= 1'b0;
         r_tag   <= 24'h000000;
         r_cdata <= 8'h00;
      end else if (r_state == S_WAIT && w_ok) begin
         r_cvld  <= 1'b1;
         r_tag   <= {r_bank, r_addr};
         r_cdata <= w_din;
      end
   end
`else
   assign w_hit = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_bank  <= 2'd0;
         r_addr  <= 22'h000000;
         r_cnt   <= 8'h00;
         r_cs    <= 3'b000;
         r_dout  <= 8'h00;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_terr  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.ROM_RD) begin
                  r_addr <= bus.ROM_ADDR[21:0];
                  r_bank <= w_bank;
                  r_cnt  <= 8'h00;
                  r_busy <= 1'b1;
                  if (w_bank == 2'd3) begin
                     r_dout  <= 8'h00;
                     r_valid <= 1'b1;
                     r_state <= S_DONE;
                  end else if (w_hit) begin
`ifdef BAKRAID_PCM_CACHE_EN
                     r_dout  <= r_cdata;
`else
                     r_dout  <= 8'h00;
`endif
                     r_valid <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cs    <= bank_cs(w_bank);
                     r_state <= S_ARM;
                  end
               end
            end
            // OK may still be high from the previous access, so it is not looked at here.
            S_ARM: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (w_ok) begin
                  r_dout  <= w_din;
                  r_valid <= 1'b1;
                  r_cs    <= 3'b000;
                  r_state <= S_DONE;
               end else if (r_cnt == TMO_LIM) begin
                  r_dout  <= 8'h00;
                  r_valid <= 1'b1;
                  r_cs    <= 3'b000;
                  r_terr  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'h01;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_cs    <= 3'b000;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.PCM_CS      = r_cs[0];
   assign bus.PCM1_CS     = r_cs[1];
   assign bus.PCM2_CS     = r_cs[2];
   assign bus.PCM_ADDR    = r_addr;
   assign bus.PCM1_ADDR   = r_addr;
   assign bus.PCM2_ADDR   = r_addr;
   assign bus.ROM_DOUT    = r_dout;
   assign bus.ROM_VALID   = r_valid;
   assign bus.BUSY        = r_busy;
   assign bus.TIMEOUT_ERR = r_terr;

endmodule

// File: tb/tb_bakraid_pcm_fetch.sv
// Scoreboard bench for bakraid_pcm_fetch: randomized requests against an address-level model,
// with a behavioural SDRAM slot responder that also injects stale OK levels and garbage.
module tb_bakraid_pcm_fetch;
   localparam int TIMEOUT  = 255;
   localparam int M_NORM   = 0;
   localparam int M_STICKY = 1;
   localparam int M_TMO    = 2;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   bakraid_pcm_fetch_if bus ();

   bakraid_pcm_fetch #(.TIMEOUT(TIMEOUT)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] dout;
      int         vedge;
      logic       err;
   } exp_t;
   exp_t sb[$];

   // Model state
   logic        m_err     = 1'b0;
   logic [7:0]  last_dout = 8'h00;
   logic        last_err  = 1'b0;
`ifdef BAKRAID_PCM_CACHE_EN
   logic        c_vld = 1'b0;
   logic [23:0] c_tag = 24'h0;
`endif

   // Expected chip-select window and latched address
   int          act_slot  = -1;
   int          act_n     = 0;
   int          act_e     = 0;
   logic [21:0] act_addr  = 22'h0;
   logic [21:0] prev_addr = 22'h0;
   logic        mon_en    = 1'b0;
   logic        abort     = 1'b0;

   // Slot responder state
   int          cur_mode = M_NORM;
   int          cur_d    = 0;
   logic [2:0]  ok_v;
   logic [7:0]  rd_v [3];
   int          cnt  [3];

   assign bus.PCM_OK    = ok_v[0];
   assign bus.PCM1_OK   = ok_v[1];
   assign bus.PCM2_OK   = ok_v[2];
   assign bus.PCM_DOUT  = rd_v[0];
   assign bus.PCM1_DOUT = rd_v[1];
   assign bus.PCM2_DOUT = rd_v[2];

   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ {a[3:0], a[7:4]} ^ 8'h5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // SDRAM slot behaviour, updated on the falling edge
   initial begin
      ok_v = 3'b000;
      for (int s = 0; s < 3; s++) begin
         rd_v[s] = 8'h00;
         cnt[s]  = 0;
      end
      forever begin
         @(negedge CLK);
         for (int s = 0; s < 3; s++) begin
            logic        cs;
            logic [21:0] sa;
            logic [23:0] full;
            case (s)
               0:       begin cs = bus.PCM_CS;  sa = bus.PCM_ADDR;  end
               1:       begin cs = bus.PCM1_CS; sa = bus.PCM1_ADDR; end
               default: begin cs = bus.PCM2_CS; sa = bus.PCM2_ADDR; end
            endcase
            full = {2'(s), sa};
            if (cs) begin
               cnt[s]++;
               if (cur_mode == M_STICKY) begin
                  ok_v[s] = 1'b1;
                  rd_v[s] = (cnt[s] == 1) ? ~mem_byte(full) : mem_byte(full);
               end else if (cur_mode == M_TMO) begin
                  ok_v[s] = 1'b0;
                  rd_v[s] = 8'($urandom);
               end else if (cnt[s] >= cur_d + 2) begin
                  ok_v[s] = 1'b1;
                  rd_v[s] = mem_byte(full);
               end else begin
                  ok_v[s] = 1'b0;
                  rd_v[s] = 8'($urandom);
               end
            end else begin
               cnt[s]  = 0;
               ok_v[s] = 1'($urandom);
               rd_v[s] = 8'($urandom);
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each ROM_VALID and checks the per-cycle invariants
   initial begin
      logic prev_valid = 1'b0;
      forever begin
         @(negedge CLK);
         if (mon_en) begin
            logic [2:0]  cs_exp;
            logic [21:0] a_exp;
            if (bus.ROM_VALID) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_valid: got ROM_VALID=1, expected no pending request (cycle %0d)", cyc);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("rom_dout",    bus.ROM_DOUT,    e.dout);
                  chk("valid_cycle", cyc,             e.vedge);
                  chk("timeout_err", bus.TIMEOUT_ERR, e.err);
                  chk("busy_done",   bus.BUSY,        1);
                  last_dout = e.dout;
                  last_err  = e.err;
               end
            end else begin
               chk("dout_hold", bus.ROM_DOUT,    last_dout);
               chk("err_hold",  bus.TIMEOUT_ERR, last_err);
            end
            if (prev_valid) chk("busy_idle", bus.BUSY, 0);
            prev_valid = bus.ROM_VALID;
            cs_exp = 3'b000;
            if (act_slot >= 0 && cyc >= act_n && cyc < act_e) cs_exp[act_slot] = 1'b1;
            chk("pcm_cs", {bus.PCM2_CS, bus.PCM1_CS, bus.PCM_CS}, cs_exp);
            a_exp = (cyc >= act_n) ? act_addr : prev_addr;
            chk("pcm_addr",  bus.PCM_ADDR,  a_exp);
            chk("pcm1_addr", bus.PCM1_ADDR, a_exp);
            chk("pcm2_addr", bus.PCM2_ADDR, a_exp);
         end
      end
   end

   // Issue one request; called at posedge+1 with the bridge idle
   task automatic do_req(input logic [23:0] a, input int mode, input int d);
      logic [1:0] b;
      logic       hit;
      int         delta;
      int         slot;
      int         n;
      int         k;
      logic       done;
      exp_t       e;
      b   = a[23:22];
      hit = 1'b0;
`ifdef BAKRAID_PCM_CACHE_EN
      hit = c_vld && (c_tag == a);
`endif
      if (b == 2'd3) begin
         delta = 1; e.dout = 8'h00; slot = -1;
      end else if (hit) begin
         delta = 1; e.dout = mem_byte(a); slot = -1;
      end else if (mode == M_TMO) begin
         delta = TIMEOUT + 3; e.dout = 8'h00; slot = int'(b); m_err = 1'b1;
      end else begin
         delta = 3 + ((mode == M_STICKY) ? 0 : d); e.dout = mem_byte(a); slot = int'(b);
`ifdef BAKRAID_PCM_CACHE_EN
         c_vld = 1'b1;
         c_tag = a;
`endif
      end
      n       = cyc + 1;
      e.vedge = n + delta - 1;
      e.err   = m_err;
      sb.push_back(e);
      cur_mode  = mode;
      cur_d     = d;
      prev_addr = act_addr;
      act_addr  = a[21:0];
      act_slot  = slot;
      act_n     = n;
      act_e     = n + delta - 1;
      bus.ROM_RD   = 1'b1;
      bus.ROM_ADDR = a;
      @(posedge CLK); #1;
      bus.ROM_RD   = 1'b0;
      bus.ROM_ADDR = 24'($urandom);
      k    = 0;
      done = 1'b0;
      while (!done && k < TIMEOUT + 20) begin
         @(negedge CLK);
         k++;
         if (bus.ROM_VALID) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL valid_wait: got no ROM_VALID in %0d cycles, expected one for addr 0x%06h", k, a);
         abort = 1'b1;
      end
      @(posedge CLK); #1;
   endtask

   // Reset while the bridge waits for OK: the request must vanish without a VALID
   task automatic reset_in_wait(input logic [23:0] a);
      int n;
      n         = cyc + 1;
      cur_mode  = M_NORM;
      cur_d     = 6;
      prev_addr = act_addr;
      act_addr  = a[21:0];
      act_slot  = int'(a[23:22]);
      act_n     = n;
      act_e     = n + 100;
      bus.ROM_RD   = 1'b1;
      bus.ROM_ADDR = a;
      @(posedge CLK); #1;
      bus.ROM_RD = 1'b0;
      @(posedge CLK); #1;
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET     = 1'b0;
      act_slot  = -1;
      act_addr  = 22'h0;
      prev_addr = 22'h0;
      last_dout = 8'h00;
      last_err  = 1'b0;
      m_err     = 1'b0;
`ifdef BAKRAID_PCM_CACHE_EN
      c_vld = 1'b0;
`endif
      @(negedge CLK);
      chk("rst_wait_busy",  bus.BUSY,      0);
      chk("rst_wait_valid", bus.ROM_VALID, 0);
      repeat (12) @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [23:0] last_a;
      RESET        = 1'b1;
      bus.ROM_RD   = 1'b0;
      bus.ROM_ADDR = 24'h0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_cs",    {bus.PCM2_CS, bus.PCM1_CS, bus.PCM_CS}, 0);
      chk("rst_addr0", bus.PCM_ADDR,    0);
      chk("rst_addr2", bus.PCM2_ADDR,   0);
      chk("rst_dout",  bus.ROM_DOUT,    0);
      chk("rst_valid", bus.ROM_VALID,   0);
      chk("rst_busy",  bus.BUSY,        0);
      chk("rst_terr",  bus.TIMEOUT_ERR, 0);
      @(posedge CLK); #1;
      RESET  = 1'b0;
      mon_en = 1'b1;
      @(posedge CLK); #1;

      do_req(24'h123456, M_NORM, 0);
      if (!abort) do_req(24'h400010, M_STICKY, 0);
      if (!abort) do_req(24'hC00000, M_NORM, 0);
      if (!abort) do_req(24'h800000, M_TMO, 0);
      if (!abort) do_req(24'h212121, M_NORM, 2);
      if (!abort) reset_in_wait(24'h000040);
      if (!abort) do_req(24'h000100, M_NORM, 1);
      if (!abort) do_req(24'h000100, M_NORM, 1);
      if (!abort) do_req(24'h000101, M_NORM, 0);

      last_a = 24'h000101;
      for (int i = 0; i < 150 && !abort; i++) begin
         logic [23:0] a;
         int          r;
         int          mode;
         r    = int'($urandom_range(0, 19));
         mode = (r == 0) ? M_TMO : (r < 5) ? M_STICKY : M_NORM;
         if ($urandom_range(0, 2) == 0) a = last_a;
         else a = {2'($urandom_range(0, 3)), 22'($urandom)};
         last_a = a;
         do_req(a, mode, int'($urandom_range(0, 4)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge CLK); #1;
         end
      end

      repeat (4) @(posedge CLK);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
